sp_ram_arbiter: RTL
===================

// Module: sp_ram_arbiter
// PURPOSE
//  Two-port request/grant front end for the single-port data RAM wrapper.
//  - Arbitrates core LSU (port 0) and AXI-slave/debug path (port 1) onto one synchronous RAM port.
//  - Decodes the window: rebases 32-bit bus addresses to byte addresses.
//  - Returns read data with an rvalid one cycle after grant; flags out-of-window accesses.
// PARAMETERS
//  RAM_SIZE     32768                byte size of the RAM behind this block
//  ADDR_WIDTH   $clog2(RAM_SIZE)     byte address width toward the RAM
//  DATA_WIDTH   32                   data width, multiple of 8
//  BASE_ADDR    32'h0010_0000        bus address of RAM byte 0
// PORTS
//  clk            in   1             clock
//  rst_i          in   1             synchronous reset, active-high
//  pN_req_i       in   1             port N request (N = 0,1), held until granted
//  pN_gnt_o       out  1             port N grant, combinational, same cycle as accepted req
//  pN_addr_i      in   32            port N byte bus address
//  pN_we_i        in   1             port N write (1) / read (0)
//  pN_be_i        in   DATA_WIDTH/8  port N byte enables
//  pN_wdata_i     in   DATA_WIDTH    port N write data
//  pN_rvalid_o    out  1             port N response, exactly 1 cycle after its grant
//  pN_rdata_o     out  DATA_WIDTH    port N read data, held until next read response of port N
//  pN_err_o       out  1             port N out-of-window error, valid with rvalid
//  ram_en_o       out  1             RAM enable
//  ram_addr_o     out  ADDR_WIDTH    RAM byte address (addr - BASE_ADDR, truncated)
//  ram_we_o       out  1             RAM write enable
//  ram_be_o       out  DATA_WIDTH/8  RAM byte enables
//  ram_wdata_o    out  DATA_WIDTH    RAM write data
//  ram_rdata_i    in   DATA_WIDTH    RAM read data, valid the cycle after ram_en_o
// BEHAVIOUR
//  - Reset (rst_i=1):
//    - gnt, rvalid, err, ram_en, ram_we, ram_be = 0; rdata = 0; last_gnt = 1 (port 0 wins first tie).
//    - A pending response is dropped; no rvalid after reset deasserts.
//  - Arbitration (one grant per cycle, no bubbles):
//    - A single requester is granted immediately.
//    - Both requesting: grant the port != last_gnt. last_gnt updates on every grant.
//    - The loser keeps req high and is granted next cycle (max wait 1 cycle).
//  - In-window access: BASE_ADDR <= addr < BASE_ADDR+RAM_SIZE.
//    - Grant cycle: ram_en_o=1; ram_we/be/wdata mirror the winner; ram_addr_o = addr-BASE_ADDR
//      (low 2 bits passed through).
//  - Out-of-window access: granted, but ram_en_o=0. Next cycle: rvalid=1, err=1, rdata unchanged.
//  - Response pipeline: 1-entry flop {valid, port_id, is_read, err}.
//    - Cycle after grant: pN_rvalid_o=1 for that port only, including writes.
//    - In-window read: rdata register of that port loads ram_rdata_i and is visible the same
//      cycle (combinational bypass on the rvalid cycle, register thereafter).
//  - Back-to-back: a grant may coincide with the rvalid of the previous grant. Full throughput:
//    1 access/cycle.
//  - Idle (no grant): ram_en_o=0, ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_wdata_o=0.
//  - Address arithmetic: 32-bit unsigned subtract; window compare on the full 32 bits before
//    truncation. No wrap into the window from below BASE_ADDR.
//  - bypass / test modes of the RAM wrapper are not driven here (tied off at the parent).
// STRUCTURE
//  - Package sp_ram_arb_pkg:
//    - typedef logic port_id_t
//    - struct resp_t {valid, port_id_t id, is_read, err}
//    - localparam DEFAULT_BASE_ADDR
//  - Sub-module rr_arb2: 2-way round-robin (req[1:0] -> gnt[1:0], last_gnt flop, sync reset).
//  - Top: window decode, request mux, resp_t flop, per-port rdata registers.
// TESTING
//  - Single read: p0 read 0x0010_0008, RAM model returns 0xCAFE_F00D.
//    -> p0_gnt same cycle; ram_addr_o=0x8; p0_rvalid +1 cycle; p0_rdata_o=0xCAFE_F00D, err=0.
//  - Contention: both req every cycle, 6 cycles.
//    -> grants alternate p0,p1,p0,p1,...; each rvalid hits only its own port, 1 cycle later.
//  - Byte write + readback: p1 write be=4'b0100 wdata=0x00AB_0000 @0x0010_0010, then read.
//    -> ram_be_o=4'b0100 on write; readback byte2=0xAB.
//  - Out-of-window: p0 read 0x0010_8000 and 0x000F_FFFC.
//    -> granted, ram_en_o=0, rvalid=1 & err=1, p0_rdata_o holds prior value.
//  - Reset mid-op: grant p0 read, assert rst_i next cycle.
//    -> p0_rvalid_o=0, rdata=0; first post-reset tie grants p0.
//  - Streaming: p0 reads 16 consecutive words with req held high.
//    -> 16 grants in 16 cycles, rvalids contiguous, data in order.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// Shared types and defaults for the single-port RAM request arbiter.
package sp_ram_arb_pkg;

   localparam int unsigned NUM_PORTS         = 2;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;

   typedef logic port_id_t;

   // Response pipeline entry: one outstanding access, answered the next cycle.
   typedef struct packed {
      logic     valid;
      port_id_t id;
      logic     is_read;
      logic     err;
   } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; port 0 wins the first tie after reset.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic last_gnt_q;
   logic last_gnt_d;

   // Grant the lone requester, or on a tie the port that did not win last.
   always_comb begin
      gnt_o      = 2'b00;
      last_gnt_d = last_gnt_q;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      if (gnt_o != 2'b00) last_gnt_d = gnt_o[1];
   end

   // Remember the most recent winner.
   always_ff @(posedge clk) begin
      if (rst_i) last_gnt_q <= 1'b1;
      else       last_gnt_q <= last_gnt_d;
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port request/grant front end onto one synchronous single-port RAM.
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int unsigned RAM_SIZE   = 32768,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    p0_req_i,
   output logic                    p0_gnt_o,
   input  logic [31:0]             p0_addr_i,
   input  logic                    p0_we_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,
   output logic                    p0_err_o,
   input  logic                    p1_req_i,
   output logic                    p1_gnt_o,
   input  logic [31:0]             p1_addr_i,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,
   output logic                    p1_err_o,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [1:0]            req;
   logic [1:0]            gnt;
   logic                  any_gnt;
   port_id_t              sel;
   logic [31:0]           addr;
   logic                  we;
   logic [BE_W-1:0]       be;
   logic [DATA_WIDTH-1:0] wdata;
   logic [31:0]           offset;
   logic                  in_win;
   resp_t                 resp_q;
   resp_t                 resp_d;
   logic [1:0]            rvalid;
   logic [1:0]            load;
   logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];
   logic [DATA_WIDTH-1:0] rdata_d [NUM_PORTS];

   assign req = {p1_req_i, p0_req_i} & {2{~rst_i}};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_i (rst_i),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign p0_gnt_o = gnt[0];
   assign p1_gnt_o = gnt[1];
   assign any_gnt  = |gnt;
   assign sel      = gnt[1];

   // Winner mux and window decode; compare on the full bus address so nothing below the base wraps in.
   always_comb begin
      addr   = sel ? p1_addr_i  : p0_addr_i;
      we     = sel ? p1_we_i    : p0_we_i;
      be     = sel ? p1_be_i    : p0_be_i;
      wdata  = sel ? p1_wdata_i : p0_wdata_i;
      offset = addr - BASE_ADDR;
      in_win = (addr >= BASE_ADDR) && (offset < 32'(RAM_SIZE));
   end

   // Drive the RAM only for granted in-window accesses; otherwise hold the port quiet.
   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (any_gnt && in_win) begin
         ram_en_o    = 1'b1;
         ram_we_o    = we;
         ram_be_o    = be;
         ram_addr_o  = offset[ADDR_WIDTH-1:0];
         ram_wdata_o = wdata;
      end
   end

   // Next response entry for the access granted this cycle.
   always_comb begin
      resp_d         = '0;
      resp_d.valid   = any_gnt;
      resp_d.id      = sel;
      resp_d.is_read = ~we;
      resp_d.err     = ~in_win;
   end

   // Steer the response to its port; in-window reads capture RAM data.
   always_comb begin
      rvalid[0] = resp_q.valid && (resp_q.id == 1'b0) && !rst_i;
      rvalid[1] = resp_q.valid && (resp_q.id == 1'b1) && !rst_i;
      load      = rvalid & {2{resp_q.is_read && !resp_q.err}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         rdata_d[i] = load[i] ? ram_rdata_i : rdata_q[i];
      end
   end

   // Response flop and per-port read data registers.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         resp_q <= '0;
         for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
      end else begin
         resp_q <= resp_d;
         for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= rdata_d[i];
      end
   end

   assign p0_rvalid_o = rvalid[0];
   assign p1_rvalid_o = rvalid[1];
   assign p0_err_o    = rvalid[0] && resp_q.err;
   assign p1_err_o    = rvalid[1] && resp_q.err;
   assign p0_rdata_o  = load[0] ? ram_rdata_i : rdata_q[0];
   assign p1_rdata_o  = load[1] ? ram_rdata_i : rdata_q[1];

endmodule
